writeback_commit: RTL
=====================

Name: writeback_commit

Overview:
Writeback/commit stage that consumes the result bundle produced by the execute stage: destination register index, result value, and next PC. It owns the architectural state:
- 32-entry general register file, exported flat to exec/dmem as curr_general_reg.
- PC register.
- Retired-instruction counter.
It detects control-flow changes, pulses a flush plus redirect to fetch/decode, and holds off new results for a fixed drain window.

Parameters:
XLEN, 32, datapath width
NREG, 32, number of general registers (x0 hardwired zero)
RESET_PC, 32'h0000_0000, PC value after reset
TRAP_PC, 32'h0000_0100, PC loaded on misaligned next-PC
FLUSH_CYCLES, 2, cycles in_ready held low after a redirect (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  exec result bundle valid
in_ready  out  1  stage can accept bundle this cycle
in_pc  in  XLEN  PC of the instruction being committed
in_rd  in  5  destination register index
in_rd_we  in  1  instruction writes rd
in_rd_value  in  XLEN  value to write to rd
in_next_pc  in  XLEN  PC computed by exec (target or pc+4)
curr_pc_reg  out  XLEN  architectural PC
curr_general_reg  out  NREG*XLEN  flat register file, entry i at [i*XLEN +: XLEN]
flush  out  1  one-cycle pulse: discard younger in-flight instructions
redirect_pc  out  XLEN  fetch target, valid while flush=1
retire_count  out  32  committed instruction count
misalign_err  out  1  sticky: a misaligned next-PC was committed

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - curr_pc_reg=RESET_PC, all registers 0, flush=0, redirect_pc=0, retire_count=0, misalign_err=0.
  - state=RUN, drain counter=0.
  - Reset overrides everything, including mid-FLUSH.
- Accept: in_valid & in_ready at a rising edge. All architectural updates become visible on outputs the cycle after accept; commit latency is 1.
- FSM states: RUN and FLUSH.
  - RUN: in_ready=1.
  - FLUSH: in_ready=0 and the drain counter decrements each cycle. On reaching 1 → RUN, so in_ready is low for exactly FLUSH_CYCLES cycles after the accept edge.
- Accept in RUN, normal case:
  - If in_rd_we=1 and in_rd≠0: reg[in_rd] ← in_rd_value.
  - Writes to x0 are discarded; x0 always reads 0.
  - curr_pc_reg ← in_next_pc; retire_count ← retire_count+1 (wraps 2^32-1 → 0).
- Redirect: accepted and in_next_pc ≠ in_pc+4 (mod 2^32), next PC aligned.
  - Next cycle: flush=1, redirect_pc=in_next_pc.
  - state → FLUSH, drain counter=FLUSH_CYCLES.
  - The rd write still occurs (JAL/JALR link value).
- Misaligned: accepted and in_next_pc[1:0] ≠ 0. This takes priority over redirect.
  - No rd write.
  - curr_pc_reg ← TRAP_PC; flush=1; redirect_pc=TRAP_PC; misalign_err ← 1.
  - retire_count does not increment.
  - state → FLUSH.
- Outside a redirect or misaligned accept: flush=0. redirect_pc holds its last value.
- in_valid while in_ready=0: no state change. Upstream must hold the bundle stable until accepted; the bundle arriving during the drain window is treated as flushed by upstream, not by this block.
- Sequential commits: back-to-back accepts in RUN, one per cycle, no bubbles.
- A read-after-write through curr_general_reg is visible to exec one cycle after the accept edge. There is no internal bypass.

Test Plan:
- Reset then idle: after rst_n deasserts → curr_pc_reg=0, all regs 0, in_ready=1, retire_count=0, flush=0.
- Sequential write: accept {pc=0, rd=5, we=1, val=0xDEADBEEF, next_pc=4} → next cycle reg5=0xDEADBEEF, curr_pc_reg=4, retire_count=1, flush=0.
- x0 write: accept {rd=0, we=1, val=0x1234, next_pc=pc+4} → reg0 stays 0, retire_count increments.
- Taken branch / JAL: accept {pc=0x40, rd=1, we=1, val=0x44, next_pc=0x80} → next cycle reg1=0x44, flush=1 for one cycle, redirect_pc=0x80, curr_pc_reg=0x80. in_ready=0 for 2 cycles, then back-to-back accepts resume.
- Misaligned target: accept {pc=0x10, rd=3, we=1, val=7, next_pc=0x22} → reg3 unchanged, curr_pc_reg=0x100, redirect_pc=0x100, flush pulse, misalign_err=1 (sticky), retire_count unchanged.
- Reset mid-FLUSH and counter wrap: assert rst_n=0 one cycle after a redirect → state RUN, in_ready=1 next cycle, all state reset. Separately, preload retire_count to 0xFFFFFFFF (force), accept one → 0.

Source files
------------

// File: rtl/writeback_commit.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_commit
//  Purpose  : Writeback/commit stage. Owns the register file, PC and
//             retired-instruction counter. Detects control-flow changes,
//             pulses flush/redirect and holds off new results while the
//             pipeline drains.
//  Revision : 1.0 - initial release
// ============================================================================
module writeback_commit #(
    parameter int               XLEN         = 32,
    parameter int               NREG         = 32,
    parameter logic [XLEN-1:0]  RESET_PC     = 32'h0000_0000,
    parameter logic [XLEN-1:0]  TRAP_PC      = 32'h0000_0100,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [4:0]           in_rd,
    input  logic                 in_rd_we,
    input  logic [XLEN-1:0]      in_rd_value,
    input  logic [XLEN-1:0]      in_next_pc,
    output logic [XLEN-1:0]      curr_pc_reg,
    output logic [NREG*XLEN-1:0] curr_general_reg,
    output logic                 flush,
    output logic [XLEN-1:0]      redirect_pc,
    output logic [31:0]          retire_count,
    output logic                 misalign_err
);

    localparam logic [0:0]      c_st_run     = 1'b0;
    localparam logic [0:0]      c_st_flush   = 1'b1;
    localparam logic [3:0]      c_drain_init = 4'(FLUSH_CYCLES);
    localparam logic [XLEN-1:0] c_pc_step    = XLEN'(4);

    logic [0:0]      state_q, state_d;
    logic [3:0]      drain_q, drain_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [31:0]     retire_q, retire_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic            misalign_q, misalign_d;

    logic            w_accept;
    logic            w_misaligned;
    logic            w_redirect;

    assign w_accept     = in_valid & in_ready;
    assign w_misaligned = (in_next_pc[1:0] != 2'b00);
    assign w_redirect   = (in_next_pc != (in_pc + c_pc_step));

    // State register plus all architectural flops; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= c_st_run;
            drain_q    <= '0;
            pc_q       <= RESET_PC;
            retire_q   <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            pc_q       <= pc_d;
            retire_q   <= retire_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Next-state: any flushing accept starts the drain window; the window
    // ends on the cycle the counter is at 1, giving FLUSH_CYCLES stall cycles
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            c_st_run: begin
                if (w_accept && (w_misaligned || w_redirect)) begin
                    state_d = c_st_flush;
                    drain_d = c_drain_init;
                end
            end
            c_st_flush: begin
                if (drain_q <= 4'd1) begin
                    state_d = c_st_run;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: begin
                state_d = c_st_run;
                drain_d = '0;
            end
        endcase
    end

    // FSM outputs: results are only accepted while running
    always_comb begin
        in_ready = (state_q == c_st_run);
    end

    // Commit datapath: a misaligned target traps instead of retiring
    always_comb begin
        pc_d       = pc_q;
        retire_d   = retire_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;
        misalign_d = misalign_q;
        regs_d     = regs_q;
        if (w_accept) begin
            if (w_misaligned) begin
                pc_d       = TRAP_PC;
                flush_d    = 1'b1;
                redirect_d = TRAP_PC;
                misalign_d = 1'b1;
            end else begin
                // x0 is never written, so it keeps its reset value of zero
                if (in_rd_we && (in_rd != 5'd0) && (int'(in_rd) < NREG)) begin
                    regs_d[in_rd] = in_rd_value;
                end
                pc_d     = in_next_pc;
                retire_d = retire_q + 32'd1;
                if (w_redirect) begin
                    flush_d    = 1'b1;
                    redirect_d = in_next_pc;
                end
            end
        end
    end

    // Flatten the register file for exec/dmem
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_flat_regs
            assign curr_general_reg[gi*XLEN +: XLEN] = regs_q[gi];
        end
    endgenerate

    assign curr_pc_reg  = pc_q;
    assign flush        = flush_q;
    assign redirect_pc  = redirect_q;
    assign retire_count = retire_q;
    assign misalign_err = misalign_q;

endmodule
`default_nettype wire
